// File: rtl/buffered_router_if.sv
// Producer/consumer bundle for buffered_router: input word stream plus per-port outputs.
// slave is the router side, master is the producer/consumer side.
interface buffered_router_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int AW = $clog2(NUM_PORTS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0]           din;
  logic                            din_en;
  logic [AW-1:0]                   addr;
  logic                            din_ready;
  logic                            addr_err;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dout;
  logic [NUM_PORTS-1:0]            dout_valid;
  logic [NUM_PORTS-1:0]            dout_ready;
  logic [NUM_PORTS-1:0]            fifo_full;
  logic [NUM_PORTS*LW-1:0]         fifo_level;

  modport master (
    output din, din_en, addr, dout_ready,
    input  din_ready, addr_err, dout, dout_valid, fifo_full, fifo_level
  );

  modport slave (
    input  din, din_en, addr, dout_ready,
    output din_ready, addr_err, dout, dout_valid, fifo_full, fifo_level
  );
endinterface

// File: rtl/buffered_router.sv
// Generic FIFO: registered pointers and level; head word readable one cycle after a push.
// Caller must not push when full or pop when empty.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (level == FULL_LVL);
endmodule

// Steers one word stream to NUM_PORTS FIFO-buffered outputs; 1 cycle to dout_valid on an empty port.
// din_ready drops only when the addressed FIFO is full (registered state, no path from dout_ready).
module buffered_router #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  buffered_router_if.slave  bus
);
  localparam int AW = $clog2(NUM_PORTS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW:0] NP_LIM = (AW+1)'(NUM_PORTS);

  logic                  addr_ok;
  logic                  full_sel;
  logic                  din_ready;
  logic                  accept;
  logic                  addr_err_q;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  pop;
  logic [NUM_PORTS-1:0]  valid;
  logic [DATA_WIDTH-1:0] head   [NUM_PORTS];
  logic [LW-1:0]         level  [NUM_PORTS];
  logic                  full_u [NUM_PORTS];
  logic [NUM_PORTS*DATA_WIDTH-1:0] dout_w;
  logic [NUM_PORTS-1:0]            full_w;
  logic [NUM_PORTS*LW-1:0]         level_w;

  // Widened compare so the bad-address check also works when NUM_PORTS is a power of 2.
  assign addr_ok = ({1'b0, bus.addr} < NP_LIM);

  always_comb begin
    full_sel = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.addr == AW'(p)) full_sel = full_u[p];
    end
  end

  assign din_ready = ~addr_ok | ~full_sel;
  assign accept    = bus.din_en & din_ready & addr_ok;

  always_comb begin
    push    = '0;
    pop     = '0;
    valid   = '0;
    dout_w  = '0;
    full_w  = '0;
    level_w = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      push[p]  = accept && (bus.addr == AW'(p));
      valid[p] = (level[p] != '0);
      pop[p]   = valid[p] & bus.dout_ready[p];
      dout_w[p*DATA_WIDTH +: DATA_WIDTH] = valid[p] ? head[p] : '0;
      full_w[p] = full_u[p];
      level_w[p*LW +: LW] = level[p];
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    sync_fifo #(
      .W     (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .push_dat (bus.din),
      .pop      (pop[g]),
      .head_dat (head[g]),
      .level    (level[g]),
      .full     (full_u[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= bus.din_en & ~addr_ok;
  end

  assign bus.din_ready  = din_ready;
  assign bus.addr_err   = addr_err_q;
  assign bus.dout       = dout_w;
  assign bus.dout_valid = valid;
  assign bus.fifo_full  = full_w;
  assign bus.fifo_level = level_w;
endmodule

// File: tb/tb_buffered_router.sv
// Scoreboard bench: stimulus queues expected words per port, a negedge monitor pops and compares.
module tb_buffered_router;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp4 [4][$];
  bit rand_rdy = 1'b0;

  buffered_router_if #(.DATA_WIDTH(32), .NUM_PORTS(4), .FIFO_DEPTH(4)) bus4();
  buffered_router_if #(.DATA_WIDTH(32), .NUM_PORTS(3), .FIFO_DEPTH(4)) bus3();

  buffered_router #(.DATA_WIDTH(32), .NUM_PORTS(4), .FIFO_DEPTH(4)) u4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );
  buffered_router #(.DATA_WIDTH(32), .NUM_PORTS(3), .FIFO_DEPTH(4)) u3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [2:0] lvl4(input int p);
    return bus4.fifo_level[p*3 +: 3];
  endfunction

  // Scoreboard monitor for the 4-port instance.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 4; p++) begin
        if (bus4.dout_valid[p] && bus4.dout_ready[p]) begin
          if (exp4[p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop port=%0d actual=%0h required=none", p, bus4.dout[p*32 +: 32]);
          end else begin
            chk($sformatf("port%0d_data", p), bus4.dout[p*32 +: 32], exp4[p].pop_front());
          end
        end else if (!bus4.dout_valid[p]) begin
          chk($sformatf("port%0d_zero_when_invalid", p), bus4.dout[p*32 +: 32], 128'h0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus4.dout_ready = 4'($urandom_range(0, 15));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send4(input logic [1:0] a, input logic [31:0] d);
    bus4.din    = d;
    bus4.addr   = a;
    bus4.din_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus4.din_ready) begin
        exp4[a].push_back(d);
        @(posedge clk);
        #1;
        bus4.din_en = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual=stalled required=accepted port=%0d", a);
    bus4.din_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus4.din = '0; bus4.din_en = 1'b0; bus4.addr = '0; bus4.dout_ready = '0;
    bus3.din = '0; bus3.din_en = 1'b0; bus3.addr = '0; bus3.dout_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_din_ready", bus4.din_ready, 1);
    chk("rst_dout_valid", bus4.dout_valid, 0);
    chk("rst_dout", bus4.dout, 0);
    chk("rst_fifo_full", bus4.fifo_full, 0);
    chk("rst_fifo_level", bus4.fifo_level, 0);
    chk("rst_addr_err", bus4.addr_err, 0);
    @(posedge clk); #1;

    // Single word to port 2
    send4(2'd2, 32'hA5A5_0001);
    bus4.dout_ready = 4'b0100;
    @(negedge clk);
    chk("t1_valid", bus4.dout_valid, 4'b0100);
    chk("t1_dout", bus4.dout, 128'h0000_0000_A5A5_0001_0000_0000_0000_0000);
    @(posedge clk); #1;
    bus4.dout_ready = 4'b0000;
    @(negedge clk);
    chk("t1_valid_cleared", bus4.dout_valid, 4'b0000);
    @(posedge clk); #1;

    // Fill port 1, then simultaneous pop with refused push
    for (int i = 1; i <= 4; i++) send4(2'd1, 32'h1111_0000 + 32'(i));
    bus4.din = 32'h1111_0005; bus4.addr = 2'd1; bus4.din_en = 1'b1;
    @(negedge clk);
    chk("t2_full", bus4.fifo_full, 4'b0010);
    chk("t2_level4", lvl4(1), 3'd4);
    chk("t2_din_ready_full", bus4.din_ready, 0);
    @(posedge clk); #1;
    bus4.dout_ready = 4'b0010;
    @(negedge clk);
    chk("t3_din_ready_full_pop", bus4.din_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_level3", lvl4(1), 3'd3);
    chk("t3_full_clear", bus4.fifo_full, 4'b0000);
    chk("t3_din_ready", bus4.din_ready, 1);
    exp4[1].push_back(32'h1111_0005);
    @(posedge clk); #1;
    bus4.din_en = 1'b0;
    for (int t = 0; t < 50 && exp4[1].size() != 0; t++) @(negedge clk);
    chk("t2_drained", 32'(exp4[1].size()), 0);
    @(negedge clk);
    chk("t2_valid_after_drain", bus4.dout_valid, 4'b0000);
    @(posedge clk); #1;
    bus4.dout_ready = 4'b0000;

    // Bad address on the 3-port instance
    bus3.din = 32'h0000_1234; bus3.addr = 2'd3; bus3.din_en = 1'b1;
    @(negedge clk);
    chk("t4_din_ready", bus3.din_ready, 1);
    chk("t4_addr_err_pre", bus3.addr_err, 0);
    @(posedge clk); #1;
    bus3.din_en = 1'b0;
    @(negedge clk);
    chk("t4_addr_err", bus3.addr_err, 1);
    chk("t4_valid", bus3.dout_valid, 0);
    chk("t4_level", bus3.fifo_level, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_addr_err_once", bus3.addr_err, 0);
    @(posedge clk); #1;
    bus3.din = 32'h0000_0055; bus3.addr = 2'd2; bus3.din_en = 1'b1;
    @(posedge clk); #1;
    bus3.din_en = 1'b0;
    @(negedge clk);
    chk("t4_good_valid", bus3.dout_valid, 3'b100);
    chk("t4_good_dout", bus3.dout, 96'h0000_0055_0000_0000_0000_0000);
    chk("t4_good_no_err", bus3.addr_err, 0);
    @(posedge clk); #1;

    // Ports 0 and 3 with random consumer readiness, >20 wraps each
    rand_rdy = 1'b1;
    for (int r = 0; r < 27; r++) begin
      for (int k = 0; k < 3; k++) send4(2'd0, 32'hC000_0000 + 32'(r*3 + k));
      for (int k = 0; k < 3; k++) send4(2'd3, 32'hD000_0000 + 32'(r*3 + k));
    end
    for (int t = 0; t < 1000 && (exp4[0].size() != 0 || exp4[3].size() != 0); t++) @(negedge clk);
    chk("t5_port0_drained", 32'(exp4[0].size()), 0);
    chk("t5_port3_drained", 32'(exp4[3].size()), 0);
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus4.dout_ready = 4'b0000;

    // Reset with buffered words and a word presented during reset
    send4(2'd0, 32'hE000_0001);
    send4(2'd0, 32'hE000_0002);
    @(negedge clk);
    chk("t6_level_pre", lvl4(0), 3'd2);
    @(posedge clk); #1;
    bus4.din = 32'hDEAD_BEEF; bus4.addr = 2'd0; bus4.din_en = 1'b1;
    rst = 1'b1;
    for (int p = 0; p < 4; p++) exp4[p].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus4.din_en = 1'b0;
    @(negedge clk);
    chk("t6_level", bus4.fifo_level, 0);
    chk("t6_valid", bus4.dout_valid, 0);
    chk("t6_dout", bus4.dout, 0);
    chk("t6_full", bus4.fifo_full, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_not_stored", bus4.dout_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
